// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Holds the control-flow type encoding, the 2-bit counter limits and the counter step helper.
package bp_pkg;

  typedef enum logic [1:0] {
    BR_TYPE_BR   = 2'd0,
    BR_TYPE_JMP  = 2'd1,
    BR_TYPE_CALL = 2'd2,
    BR_TYPE_RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CTR_MIN          = 2'b00;
  localparam logic [1:0] CTR_MAX          = 2'b11;
  localparam logic [1:0] CTR_INIT_DEFAULT = 2'b10;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] n;
    n = c;
    if (taken && c != CTR_MAX)
      n = c + 2'd1;
    else if (!taken && c != CTR_MIN)
      n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Return address stack with speculative and committed pointer/count pairs.
// Ports: i_clk, i_rst (sync, active-high), spec/commit push+pop, i_recover; o_top, o_nonempty.
module bp_ras
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RAS_ENTRIES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_spec_push,
  input  logic            i_spec_pop,
  input  logic [XLEN-1:0] i_spec_data,
  input  logic            i_commit_push,
  input  logic            i_commit_pop,
  input  logic [XLEN-1:0] i_commit_data,
  input  logic            i_recover,
  output logic [XLEN-1:0] o_top,
  output logic            o_nonempty
);

  localparam int PTR_W = $clog2(RAS_ENTRIES);
  localparam int CNT_W = $clog2(RAS_ENTRIES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_ENTRIES);
  localparam logic [PTR_W-1:0] P1      = PTR_W'(1);
  localparam logic [CNT_W-1:0] C1      = CNT_W'(1);

  logic [XLEN-1:0]  r_stack [RAS_ENTRIES];
  logic [PTR_W-1:0] r_sptr;
  logic [CNT_W-1:0] r_scnt;
  logic [PTR_W-1:0] r_cptr;
  logic [CNT_W-1:0] r_ccnt;

  logic [PTR_W-1:0] w_sptr_nxt;
  logic [CNT_W-1:0] w_scnt_nxt;
  logic [PTR_W-1:0] w_cptr_nxt;
  logic [CNT_W-1:0] w_ccnt_nxt;
  logic [PTR_W-1:0] w_spush_idx;
  logic [PTR_W-1:0] w_cpush_idx;

  assign w_spush_idx = r_sptr + P1;
  assign w_cpush_idx = r_cptr + P1;

  // Push overwrites the oldest slot once full; count pins at depth.
  always_comb begin
    w_cptr_nxt = r_cptr;
    w_ccnt_nxt = r_ccnt;
    if (i_commit_push) begin
      w_cptr_nxt = r_cptr + P1;
      w_ccnt_nxt = (r_ccnt == CNT_MAX) ? r_ccnt : r_ccnt + C1;
    end else if (i_commit_pop && r_ccnt != '0) begin
      w_cptr_nxt = r_cptr - P1;
      w_ccnt_nxt = r_ccnt - C1;
    end
  end

  always_comb begin
    w_sptr_nxt = r_sptr;
    w_scnt_nxt = r_scnt;
    if (i_spec_push) begin
      w_sptr_nxt = r_sptr + P1;
      w_scnt_nxt = (r_scnt == CNT_MAX) ? r_scnt : r_scnt + C1;
    end else if (i_spec_pop && r_scnt != '0) begin
      w_sptr_nxt = r_sptr - P1;
      w_scnt_nxt = r_scnt - C1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RAS_ENTRIES; i++)
        r_stack[i] <= '0;
      r_sptr <= '0;
      r_scnt <= '0;
      r_cptr <= '0;
      r_ccnt <= '0;
    end else begin
      if (i_commit_push)
        r_stack[w_cpush_idx] <= i_commit_data;
      // Youngest write wins a slot collision.
      if (i_spec_push && !i_recover)
        r_stack[w_spush_idx] <= i_spec_data;
      r_cptr <= w_cptr_nxt;
      r_ccnt <= w_ccnt_nxt;
      if (i_recover) begin
        r_sptr <= w_cptr_nxt;
        r_scnt <= w_ccnt_nxt;
      end else begin
        r_sptr <= w_sptr_nxt;
        r_scnt <= w_scnt_nxt;
      end
    end
  end

  assign o_top      = r_stack[r_sptr];
  assign o_nonempty = (r_scnt != '0);

endmodule

// File: rtl/bp_gshare.sv
// Gshare predictor: PHT indexed by PC^GHR, fully associative BTB, speculative GHR, RAS.
// Ports: ck_i/rs_i, fetch lookup (pc_i, fetch_valid_i -> pred_*), resolved update (upd_*).
module bp_gshare
  import bp_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         PHT_ENTRIES = 256,
  parameter int         GHR_W       = 8,
  parameter int         BTB_ENTRIES = 32,
  parameter int         RAS_ENTRIES = 8,
  parameter logic [1:0] CTR_INIT    = CTR_INIT_DEFAULT
) (
  input  logic             ck_i,
  input  logic             rs_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             fetch_valid_i,
  output logic [XLEN-1:0]  pred_pc_o,
  output logic             pred_taken_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [1:0]       upd_type_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_mispredict_i,
  input  logic [GHR_W-1:0] upd_ghr_i
);

  localparam int IDX_W  = $clog2(PHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [1:0]        r_pht     [PHT_ENTRIES];
  logic [GHR_W-1:0]  r_ghr;
  logic              r_btb_vld [BTB_ENTRIES];
  logic [XLEN-1:0]   r_btb_tag [BTB_ENTRIES];
  br_type_e          r_btb_typ [BTB_ENTRIES];
  logic [XLEN-1:0]   r_btb_tgt [BTB_ENTRIES];
  logic [BTB_IW-1:0] r_rr;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_uidx;
  logic              w_dir;
  logic              w_hit;
  logic [BTB_IW-1:0] w_hit_idx;
  logic              w_uhit;
  logic [BTB_IW-1:0] w_uhit_idx;
  logic              w_free;
  logic [BTB_IW-1:0] w_free_idx;
  logic [BTB_IW-1:0] w_widx;
  br_type_e          w_htyp;
  logic [XLEN-1:0]   w_htgt;
  logic              w_is_br;
  logic              w_is_jmp;
  logic              w_is_call;
  logic              w_is_ret;
  logic              w_flush;
  logic              w_btb_we;
  logic              w_upd_br;
  logic [XLEN-1:0]   w_seq;
  logic [XLEN-1:0]   w_ras_top;
  logic              w_ras_ne;

  assign w_idx  = pc_i[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_uidx = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_ghr_i);
  assign w_dir  = r_pht[w_idx][1];
  assign w_seq  = pc_i + FOUR;

  // Descending scans so the lowest matching index is the one kept.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (r_btb_vld[i] && r_btb_tag[i] == pc_i) begin
        w_hit     = 1'b1;
        w_hit_idx = BTB_IW'(i);
      end
    end
  end

  always_comb begin
    w_uhit     = 1'b0;
    w_uhit_idx = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (r_btb_vld[i] && r_btb_tag[i] == upd_pc_i) begin
        w_uhit     = 1'b1;
        w_uhit_idx = BTB_IW'(i);
      end
      if (!r_btb_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = BTB_IW'(i);
      end
    end
  end

  assign w_htyp    = r_btb_typ[w_hit_idx];
  assign w_htgt    = r_btb_tgt[w_hit_idx];
  assign w_is_br   = w_hit && (w_htyp == BR_TYPE_BR);
  assign w_is_jmp  = w_hit && (w_htyp == BR_TYPE_JMP);
  assign w_is_call = w_hit && (w_htyp == BR_TYPE_CALL);
  assign w_is_ret  = w_hit && (w_htyp == BR_TYPE_RET);

  assign w_flush  = upd_valid_i && upd_mispredict_i;
  assign w_upd_br = upd_valid_i && (upd_type_i == BR_TYPE_BR);
  assign w_btb_we = upd_valid_i && (upd_taken_i || w_uhit);
  assign w_widx   = w_uhit ? w_uhit_idx :
                    (w_free ? w_free_idx : r_rr);

  always_comb begin
    pred_pc_o    = w_seq;
    pred_taken_o = 1'b0;
    priority case (1'b1)
      rs_i: begin
        pred_pc_o    = w_seq;
        pred_taken_o = 1'b0;
      end
      (w_is_ret && w_ras_ne): begin
        pred_pc_o    = w_ras_top;
        pred_taken_o = 1'b1;
      end
      (w_is_jmp || w_is_call): begin
        pred_pc_o    = w_htgt;
        pred_taken_o = 1'b1;
      end
      (w_is_br && w_dir): begin
        pred_pc_o    = w_htgt;
        pred_taken_o = 1'b1;
      end
      default: begin
        pred_pc_o    = w_seq;
        pred_taken_o = 1'b0;
      end
    endcase
  end

  assign pred_ghr_o = rs_i ? '0 : r_ghr;

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        r_pht[i] <= CTR_INIT;
    end else if (w_upd_br) begin
      r_pht[w_uidx] <= ctr_next(r_pht[w_uidx], upd_taken_i);
    end
  end

  // A flushing update discards whatever this cycle's fetch would shift in.
  always_ff @(posedge ck_i) begin
    if (rs_i)
      r_ghr <= '0;
    else if (w_flush)
      r_ghr <= (upd_type_i == BR_TYPE_BR) ?
               GHR_W'({upd_ghr_i, upd_taken_i}) : upd_ghr_i;
    else if (fetch_valid_i && w_is_br)
      r_ghr <= GHR_W'({r_ghr, w_dir});
  end

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_vld[i] <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_typ[i] <= BR_TYPE_BR;
        r_btb_tgt[i] <= '0;
      end
      r_rr <= '0;
    end else if (w_btb_we) begin
      r_btb_vld[w_widx] <= 1'b1;
      r_btb_tag[w_widx] <= upd_pc_i;
      r_btb_typ[w_widx] <= br_type_e'(upd_type_i);
      r_btb_tgt[w_widx] <= upd_target_i;
      if (!w_uhit && !w_free)
        r_rr <= r_rr + BTB_IW'(1);
    end
  end

  bp_ras #(
    .XLEN        (XLEN),
    .RAS_ENTRIES (RAS_ENTRIES)
  ) u_ras (
    .i_clk         (ck_i),
    .i_rst         (rs_i),
    .i_spec_push   (fetch_valid_i && w_is_call && !w_flush),
    .i_spec_pop    (fetch_valid_i && w_is_ret && w_ras_ne && !w_flush),
    .i_spec_data   (w_seq),
    .i_commit_push (upd_valid_i && upd_type_i == BR_TYPE_CALL),
    .i_commit_pop  (upd_valid_i && upd_type_i == BR_TYPE_RET),
    .i_commit_data (upd_pc_i + FOUR),
    .i_recover     (w_flush),
    .o_top         (w_ras_top),
    .o_nonempty    (w_ras_ne)
  );

endmodule

// File: tb/tb_bp_gshare.sv
// Directed bench for bp_gshare.
// Walks reset, PHT training, GHR, RAS, BTB replacement and flush priority.
module tb_bp_gshare;

  localparam logic [1:0] T_BR   = 2'd0;
  localparam logic [1:0] T_JMP  = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  logic        ck_i = 1'b0;
  logic        rs_i;
  logic [31:0] pc_i;
  logic        fetch_valid_i;
  logic [31:0] pred_pc_o;
  logic        pred_taken_o;
  logic [7:0]  pred_ghr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [1:0]  upd_type_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispredict_i;
  logic [7:0]  upd_ghr_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ck_i = ~ck_i;

  bp_gshare dut (
    .ck_i             (ck_i),
    .rs_i             (rs_i),
    .pc_i             (pc_i),
    .fetch_valid_i    (fetch_valid_i),
    .pred_pc_o        (pred_pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_type_i       (upd_type_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_mispredict_i (upd_mispredict_i),
    .upd_ghr_i        (upd_ghr_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck_i);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc,
                         input logic [1:0]  ty,
                         input logic        tk,
                         input logic [31:0] tg,
                         input logic        mis,
                         input logic [7:0]  g);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_type_i       = ty;
    upd_taken_i      = tk;
    upd_target_i     = tg;
    upd_mispredict_i = mis;
    upd_ghr_i        = g;
  endtask

  task automatic clr_upd();
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic [1:0]  ty,
                     input logic        tk,
                     input logic [31:0] tg,
                     input logic        mis,
                     input logic [7:0]  g);
    set_upd(pc, ty, tk, tg, mis, g);
    tick();
    clr_upd();
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_i          = pc;
    fetch_valid_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic look(input string tag,
                      input logic [31:0] pc,
                      input logic [31:0] epc,
                      input logic        etk);
    pc_i          = pc;
    fetch_valid_i = 1'b0;
    #1;
    chk({tag, "_pc"}, pred_pc_o, epc);
    chk({tag, "_tk"}, {31'd0, pred_taken_o}, {31'd0, etk});
  endtask

  task automatic ghr(input string tag, input logic [7:0] e);
    #1;
    chk(tag, {24'd0, pred_ghr_o}, {24'd0, e});
  endtask

  initial begin
    rs_i          = 1'b1;
    pc_i          = 32'h100;
    fetch_valid_i = 1'b0;
    upd_pc_i      = '0;
    upd_type_i    = '0;
    upd_taken_i   = 1'b0;
    upd_target_i  = '0;
    upd_ghr_i     = '0;
    clr_upd();
    #2;
    chk("rst_in_pc", pred_pc_o, 32'h104);
    chk("rst_in_tk", {31'd0, pred_taken_o}, 32'd0);
    chk("rst_in_ghr", {24'd0, pred_ghr_o}, 32'd0);
    tick();
    tick();
    rs_i = 1'b0;
    look("rst_out", 32'h100, 32'h104, 1'b0);
    ghr("rst_out_ghr", 8'h00);

    // BR at 0x200 -> 0x400; PHT index 0x80 while GHR = 0
    pc_i = 32'h200;
    set_upd(32'h200, T_BR, 1'b1, 32'h400, 1'b0, 8'h00);
    #1;
    chk("same_cyc_old", pred_pc_o, 32'h204);
    tick();
    clr_upd();
    look("br_ctr3", 32'h200, 32'h400, 1'b1);
    repeat (2) upd(32'h200, T_BR, 1'b0, 32'h400, 1'b0, 8'h00);
    look("br_ctr1", 32'h200, 32'h204, 1'b0);
    repeat (2) upd(32'h200, T_BR, 1'b0, 32'h400, 1'b0, 8'h00);
    upd(32'h200, T_BR, 1'b1, 32'h400, 1'b0, 8'h00);
    look("br_sat0", 32'h200, 32'h204, 1'b0);
    upd(32'h200, T_BR, 1'b1, 32'h400, 1'b0, 8'h00);
    look("br_ctr2", 32'h200, 32'h400, 1'b1);
    repeat (3) upd(32'h200, T_BR, 1'b1, 32'h400, 1'b0, 8'h00);
    upd(32'h200, T_BR, 1'b0, 32'h400, 1'b0, 8'h00);
    look("br_sat3", 32'h200, 32'h400, 1'b1);

    // GHR: taken fetch shifts in 1, index moves to 0x81
    fetch(32'h200);
    ghr("ghr_shift1", 8'h01);
    repeat (2) upd(32'h200, T_BR, 1'b0, 32'h400, 1'b0, 8'h01);
    look("ghr_idx81", 32'h200, 32'h204, 1'b0);
    fetch(32'h200);
    ghr("ghr_shift0", 8'h02);
    look("ghr_idx82", 32'h200, 32'h400, 1'b1);
    upd(32'h200, T_BR, 1'b0, 32'h400, 1'b1, 8'h5A);
    ghr("ghr_br_mis", 8'hB4);
    upd(32'h280, T_JMP, 1'b1, 32'h500, 1'b1, 8'h33);
    ghr("ghr_jmp_mis", 8'h33);
    look("jmp", 32'h280, 32'h500, 1'b1);
    pc_i = 32'h200;
    tick();
    ghr("ghr_hold", 8'h33);

    // RAS basic
    upd(32'h300, T_CALL, 1'b1, 32'h800, 1'b0, 8'h00);
    upd(32'h810, T_RET, 1'b1, 32'h304, 1'b0, 8'h00);
    look("call", 32'h300, 32'h800, 1'b1);
    fetch(32'h300);
    look("ret", 32'h810, 32'h304, 1'b1);
    fetch(32'h810);
    look("ret_empty", 32'h810, 32'h814, 1'b0);

    // RAS overflow: nine calls, eight returns survive
    for (int k = 0; k < 9; k++)
      upd(32'h1000 + 32'(16 * k), T_CALL, 1'b1, 32'h2000, 1'b0, 8'h00);
    for (int k = 0; k < 9; k++)
      fetch(32'h1000 + 32'(16 * k));
    for (int j = 0; j < 8; j++) begin
      look($sformatf("ovf_pop%0d", j), 32'h810,
           32'h1004 + 32'(16 * (8 - j)), 1'b1);
      fetch(32'h810);
    end
    look("ovf_empty", 32'h810, 32'h814, 1'b0);

    // Flush beats a same-cycle fetch CALL push
    pc_i          = 32'h300;
    fetch_valid_i = 1'b1;
    set_upd(32'h280, T_JMP, 1'b1, 32'h500, 1'b1, 8'h11);
    tick();
    clr_upd();
    fetch_valid_i = 1'b0;
    ghr("sim_ghr", 8'h11);
    look("sim_top", 32'h810, 32'h1084, 1'b1);
    fetch(32'h810);
    look("sim_pop", 32'h810, 32'h1074, 1'b1);

    // BTB: 13 used, fill the remaining 19, then two round-robin victims
    for (int k = 0; k < 19; k++)
      upd(32'h4000 + 32'(4 * k), T_JMP, 1'b1,
          32'h6000 + 32'(4 * k), 1'b0, 8'h00);
    look("btb_last", 32'h4048, 32'h6048, 1'b1);
    upd(32'h5000, T_JMP, 1'b1, 32'h7000, 1'b0, 8'h00);
    look("rep0_gone", 32'h200, 32'h204, 1'b0);
    look("rep0_new", 32'h5000, 32'h7000, 1'b1);
    look("rep1_kept", 32'h280, 32'h500, 1'b1);
    upd(32'h5004, T_JMP, 1'b1, 32'h7004, 1'b0, 8'h00);
    look("rep1_gone", 32'h280, 32'h284, 1'b0);
    look("rep1_new", 32'h5004, 32'h7004, 1'b1);
    upd(32'h6100, T_BR, 1'b0, 32'h9000, 1'b0, 8'h00);
    look("nt_noalloc", 32'h6100, 32'h6104, 1'b0);
    look("rep2_kept", 32'h300, 32'h800, 1'b1);

    // Reset overrides concurrent update and fetch
    rs_i          = 1'b1;
    pc_i          = 32'h5000;
    fetch_valid_i = 1'b1;
    set_upd(32'h6200, T_JMP, 1'b1, 32'h6300, 1'b1, 8'h77);
    #1;
    chk("rst_mid_pc", pred_pc_o, 32'h5004);
    tick();
    clr_upd();
    fetch_valid_i = 1'b0;
    rs_i          = 1'b0;
    look("rst_btb", 32'h5000, 32'h5004, 1'b0);
    ghr("rst_ghr", 8'h00);
    look("rst_noupd", 32'h6200, 32'h6204, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
